uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver for the Segway: deserializes the 8N1 UART stream that the BLE module (modelled on the bench by the UART transmitter) drives onto `RX`, and presents each byte to the command logic with a ready/clear handshake. It is the receive end of the command link. It includes:
- metastability synchronization of the pin,
- mid-bit sampling with false-start rejection,
- framing-error detection and break handling,
- overrun flagging.

## Interface
- `BAUD_DIV`, default 2604, clocks per bit (50 MHz / 19200 baud); must be ≥ 4.
- `HALF`, default `BAUD_DIV/2`, clocks from start-edge detection to start-bit sample.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `RX`  in  1  asynchronous serial input; idles high.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`, `frm_err`, `ovr_err`.
- `rx_data`  out  8  last correctly framed byte.
- `rdy`  out  1  a new byte is held in `rx_data`.
- `frm_err`  out  1  sticky: stop bit sampled low.
- `ovr_err`  out  1  sticky: a byte was overwritten while `rdy` was still set.

## Operation
- **Synchronizer:** two flops on `RX`. Both reset to 1. `rx_s` is the second flop.
- **Baud counter:** `baud_cnt` is a down-counter, 12 bits or wider. A sample point occurs on the cycle where `baud_cnt == 0`. Each load is followed by a decrement every cycle.
- **Bit counter:** `bit_cnt` is 4 bits.
- **Shift register:** `shft` is 8 bits. On each data sample it shifts right, with `rx_s` entering the MSB. Bytes are therefore received LSB first.
- **IDLE:**
  - If `rx_s == 0`: load `baud_cnt = HALF`, go to START.
- **START:** at the sample point:
  - If `rx_s == 1`: false start. Return to IDLE; no flags change.
  - Otherwise: load `baud_cnt = BAUD_DIV`, clear `bit_cnt`, go to DATA.
- **DATA:** at each sample point:
  - Shift `rx_s` into `shft`, increment `bit_cnt`, reload `BAUD_DIV`.
  - After the 8th shift, go to STOP.
- **STOP:** at the sample point:
  - If `rx_s == 1`:
    - `rx_data <= shft` and `rdy <= 1`.
    - If `rdy` was already 1 and `clr_rdy` is low this cycle, set `ovr_err`.
    - Go to IDLE.
  - If `rx_s == 0`:
    - Set `frm_err`. `rx_data` and `rdy` are unchanged.
    - Go to WAIT_HI.
- **WAIT_HI:** stay until `rx_s == 1`, then go to IDLE. This rule holds for a break condition too: the block never re-triggers on a held-low line.
- **clr_rdy:** clears `rdy`, `frm_err` and `ovr_err` on the next edge.
  - If a set event occurs in the same cycle, the set wins for that flag.
  - `clr_rdy` does not affect the FSM.
- **rst:** on the next edge, from any state including mid-frame:
  - State → IDLE, counters → 0, `shft` and `rx_data` → 0x00.
  - `rdy`, `frm_err`, `ovr_err` → 0.
  - Synchronizer flops → 1.

## Timing
- **Reset values:** `rx_data` = 0x00; `rdy` = `frm_err` = `ovr_err` = 0.
- **Pin to detection:** a falling edge on `RX` appears on `rx_s` 2 cycles later. Call that cycle t0 (the IDLE detection cycle).
- **Sample points:**
  - Start bit: t0 + `HALF`.
  - Data bit i (i = 0..7): t0 + `HALF` + (i+1)·`BAUD_DIV`.
  - Stop bit: t0 + `HALF` + 9·`BAUD_DIV`.
- **Output update:** `rdy`, `rx_data` and `frm_err` update on the edge that ends the stop-sample cycle, i.e. they are visible from the following cycle.
- **Back-to-back frames:** the FSM is in IDLE one cycle after the stop sample. It accepts a next start edge arriving at t0 + `HALF` + 9·`BAUD_DIV` + 1 or later. Throughput is continuous at the nominal baud.
- **Clock tolerance:** ±`HALF` clocks of accumulated drift over 10 bits is tolerated.
- **Output timing:** outputs are registered; there is no combinational path from `RX` or `clr_rdy` to any output.

## Test plan
- **Nominal byte:** `BAUD_DIV` = 2604; UART_tx sends 0xA5.
  - `rdy` rises at t0 + 1302 + 9·2604 + 1.
  - `rx_data` = 0xA5; `frm_err` = 0; `ovr_err` = 0.
- **False start:** `RX` glitches low for 500 cycles, then a 0x3C frame follows.
  - No `rdy` from the glitch; FSM returns to IDLE.
  - 0x3C is then received with `rdy` = 1.
- **Framing error / break:** frame 0x00 with the stop bit held low, and the line held low for 20·`BAUD_DIV`.
  - `frm_err` = 1; `rdy` = 0; `rx_data` unchanged.
  - No further frames are decoded until `RX` returns high.
  - A following 0x81 is then received correctly.
- **Overrun:** 0x11 then 0x22 sent back-to-back with no `clr_rdy`.
  - `rx_data` = 0x22; `rdy` = 1; `ovr_err` = 1.
  - A single `clr_rdy` pulse → all three flags 0 next cycle.
- **Simultaneous clear and complete:** `clr_rdy` pulsed exactly in the stop-sample cycle of 0x7E, with `rdy` previously 1.
  - `rdy` = 1 afterwards; `rx_data` = 0x7E; `ovr_err` = 0.
- **Reset mid-frame:** `rst` asserted during DATA bit 4 of 0xFF.
  - Next cycle: all outputs at reset values, FSM in IDLE.
  - A subsequent 0x5A is received with `rdy` = 1 and `rx_data` = 0x5A.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
// Command-link receive bundle: serial pin and consumer handshake on one side,
// received byte and status flags on the other.
interface uart_cmd_rx_if;
  logic       RX;       // serial line, idles high
  logic       clr_rdy;  // consumer acknowledge
  logic [7:0] rx_data;  // last correctly framed byte
  logic       rdy;      // new byte held in rx_data
  logic       frm_err;  // sticky: stop bit sampled low
  logic       ovr_err;  // sticky: byte overwritten while rdy set

  // master: the receiver block
  modport master (
    input  RX, clr_rdy,
    output rx_data, rdy, frm_err, ovr_err
  );

  // slave: the line driver / command consumer
  modport slave (
    output RX, clr_rdy,
    input  rx_data, rdy, frm_err, ovr_err
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the Segway command link. Two-flop pin synchronizer,
// mid-bit sampling with false-start rejection, framing-error/break handling
// and overrun flagging; bytes are presented with a rdy / clr_rdy handshake.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604,        // clocks per bit
  parameter int HALF     = BAUD_DIV/2   // start-edge detect to start-bit sample
) (
  input  logic          clk,
  input  logic          rst,
  uart_cmd_rx_if.master bus
);

  // Counter is at least 12 bits, wider if BAUD_DIV needs it.
  localparam int CW_MIN = $clog2(BAUD_DIV + 1);
  localparam int CW     = (CW_MIN > 12) ? CW_MIN : 12;

  // The counter is loaded with (interval - 1) so that the cycle on which it
  // reaches zero lies exactly HALF / BAUD_DIV cycles after the loading cycle.
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

  if (BAUD_DIV < 4) begin : g_bad_div
    $error("uart_cmd_rx: BAUD_DIV must be >= 4");
  end
  if (HALF < 1 || HALF >= BAUD_DIV) begin : g_bad_half
    $error("uart_cmd_rx: HALF must lie in [1, BAUD_DIV-1]");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shft_q, shft_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdy_q, rdy_d;
  logic            frm_q, frm_d;
  logic            ovr_q, ovr_d;

  logic            sample;
  logic            rdy_set, frm_set, ovr_set;

  assign sample = (baud_cnt_q == '0);

  // Pin synchronizer; both stages reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shft_q     <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shft_q     <= shft_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_q      <= frm_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state, sampling and flag set/clear logic.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = (baud_cnt_q != '0) ? (baud_cnt_q - CW'(1)) : '0;
    bit_cnt_d  = bit_cnt_q;
    shft_d     = shft_q;
    rx_data_d  = rx_data_q;
    rdy_set    = 1'b0;
    frm_set    = 1'b0;
    ovr_set    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          baud_cnt_d = HALF_LD;
          state_d    = START;
        end
      end

      START: begin
        if (sample) begin
          if (rx_s_q) begin
            // Line back high by mid start bit: a glitch, not a frame.
            state_d = IDLE;
          end else begin
            baud_cnt_d = FULL_LD;
            bit_cnt_d  = '0;
            state_d    = DATA;
          end
        end
      end

      DATA: begin
        if (sample) begin
          shft_d     = {rx_s_q, shft_q[7:1]};   // LSB first
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = FULL_LD;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end

      STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            rx_data_d = shft_q;
            rdy_set   = 1'b1;
            // An acknowledge in this very cycle means the old byte was taken.
            if (rdy_q && !bus.clr_rdy) ovr_set = 1'b1;
            state_d   = IDLE;
          end else begin
            // Keep the last good byte; wait out the low line (break).
            frm_set = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end

      WAIT_HI: begin
        if (rx_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Sticky flags: a set in the same cycle as clr_rdy wins.
    rdy_d = rdy_set | (rdy_q & ~bus.clr_rdy);
    frm_d = frm_set | (frm_q & ~bus.clr_rdy);
    ovr_d = ovr_set | (ovr_q & ~bus.clr_rdy);
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_q;
  assign bus.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: a fast instance (BAUD_DIV=16) for the functional
// scenarios and a default-parameter instance for the nominal 19200-baud byte
// with exact rdy timing. Stimulus pushes expected output tuples; the monitor
// pops one on every change of a DUT's outputs.
module tb_uart_cmd_rx;
  localparam int B  = 16;
  localparam int H  = 8;
  localparam int BN = 2604;
  localparam int HN = 1302;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       o;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_rx_if u_if ();
  uart_cmd_rx_if n_if ();

  uart_cmd_rx #(.BAUD_DIV(B), .HALF(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  uart_cmd_rx dut_n (
    .clk (clk),
    .rst (rst),
    .bus (n_if)
  );

  obs_t exp_q[$];    // expected output changes, fast instance
  obs_t snap_q[$];   // expected output at the next sample, fast instance
  obs_t expn_q[$];   // expected output changes, nominal instance
  int   expn_cyc[$]; // expected cycle count of each nominal change

  int n_cmp = 0;
  int n_bad = 0;

  function automatic string fmt(obs_t o);
    return $sformatf("data=%02h rdy=%0b frm=%0b ovr=%0b", o.d, o.r, o.f, o.o);
  endfunction

  // Scoreboard monitor; all comparisons happen here.
  obs_t cur_s, cur_n, prev_s, prev_n, e;
  int   ec;
  always @(negedge clk) begin
    cur_s = {u_if.rx_data, u_if.rdy, u_if.frm_err, u_if.ovr_err};
    cur_n = {n_if.rx_data, n_if.rdy, n_if.frm_err, n_if.ovr_err};
    if (mon_en) begin
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        n_cmp++;
        if (cur_s != e) begin
          n_bad++;
          $display("FAIL snapshot @%0d: got %s, want %s", cyc, fmt(cur_s), fmt(e));
        end
      end
      if (cur_s != prev_s) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected change @%0d: got %s, want no change", cyc, fmt(cur_s));
        end else begin
          e = exp_q.pop_front();
          if (cur_s != e) begin
            n_bad++;
            $display("FAIL change @%0d: got %s, want %s", cyc, fmt(cur_s), fmt(e));
          end
        end
      end
      if (cur_n != prev_n) begin
        n_cmp++;
        if (expn_q.size() == 0) begin
          n_bad++;
          $display("FAIL nominal unexpected change @%0d: got %s", cyc, fmt(cur_n));
        end else begin
          e  = expn_q.pop_front();
          ec = expn_cyc.pop_front();
          if (cur_n != e) begin
            n_bad++;
            $display("FAIL nominal change: got %s, want %s", fmt(cur_n), fmt(e));
          end
          n_cmp++;
          if (cyc != ec) begin
            n_bad++;
            $display("FAIL nominal rdy timing: got cycle %0d, want cycle %0d", cyc, ec);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
          n_bad++;
          $display("FAIL pending fast-instance expectations: got %0d left, want 0",
                   exp_q.size() + snap_q.size());
        end
        n_cmp++;
        if (expn_q.size() != 0) begin
          n_bad++;
          $display("FAIL pending nominal expectations: got %0d left, want 0", expn_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
    prev_s = cur_s;
    prev_n = cur_n;
  end

  // Advance n clocks and land 1 time unit after the edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, starting 1 unit after an edge. clr_k pulses clr_rdy at
  // that offset within the stop bit; rst_at pulses rst mid-way through that
  // bit index (0 = start bit). The stop level is left on the line.
  task automatic send(input bit nom, input logic [7:0] d, input logic stop,
                      input int clr_k, input int rst_at);
    logic [9:0] fr;
    int bw;
    fr = {stop, d, 1'b0};
    bw = nom ? BN : B;
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < bw; k++) begin
        if (nom) n_if.RX = fr[j];
        else     u_if.RX = fr[j];
        u_if.clr_rdy = (j == 9 && k == clr_k);
        rst          = (j == rst_at && k == H);
        @(posedge clk);
        #1;
      end
    end
    u_if.clr_rdy = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic clr_pulse();
    u_if.clr_rdy = 1'b1;
    idle(1);
    u_if.clr_rdy = 1'b0;
  endtask

  initial begin
    u_if.RX = 1'b1;  u_if.clr_rdy = 1'b0;
    n_if.RX = 1'b1;  n_if.clr_rdy = 1'b0;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    mon_en = 1'b1;
    snap_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});   // reset state
    idle(3);

    // Plain byte, then acknowledge.
    exp_q.push_back('{8'hA5, 1'b1, 1'b0, 1'b0});
    send(0, 8'hA5, 1'b1, -1, -1);
    idle(3);
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    clr_pulse();
    idle(3);

    // Glitch shorter than HALF, then a real frame.
    u_if.RX = 1'b0;
    idle(4);
    u_if.RX = 1'b1;
    idle(2*B);
    exp_q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
    send(0, 8'h3C, 1'b1, -1, -1);
    idle(3);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    clr_pulse();
    idle(3);

    // Framing error into a break: line low for 20 bit times.
    exp_q.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
    send(0, 8'h00, 1'b0, -1, -1);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    clr_pulse();
    idle(10*B - 1);
    u_if.RX = 1'b1;
    idle(2*B);
    exp_q.push_back('{8'h81, 1'b1, 1'b0, 1'b0});
    send(0, 8'h81, 1'b1, -1, -1);
    idle(3);
    exp_q.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    clr_pulse();
    idle(3);

    // Overrun: two frames back to back with no acknowledge.
    exp_q.push_back('{8'h11, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{8'h22, 1'b1, 1'b0, 1'b1});
    send(0, 8'h11, 1'b1, -1, -1);
    send(0, 8'h22, 1'b1, -1, -1);
    idle(3);
    exp_q.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
    clr_pulse();
    snap_q.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
    idle(3);

    // clr_rdy in the stop-sample cycle of a frame while rdy is set.
    exp_q.push_back('{8'h33, 1'b1, 1'b0, 1'b0});
    send(0, 8'h33, 1'b1, -1, -1);
    idle(3);
    exp_q.push_back('{8'h7E, 1'b1, 1'b0, 1'b0});
    send(0, 8'h7E, 1'b1, H + 2, -1);
    idle(3);

    // Reset during data bit 4 of 0xFF, then a fresh frame.
    exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
    send(0, 8'hFF, 1'b1, -1, 5);
    idle(3);
    exp_q.push_back('{8'h5A, 1'b1, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b1, -1, -1);
    idle(3);

    // Nominal-rate instance: 500-cycle glitch, then 0xA5 with exact timing.
    n_if.RX = 1'b0;
    idle(500);
    n_if.RX = 1'b1;
    idle(3000);
    expn_q.push_back('{8'hA5, 1'b1, 1'b0, 1'b0});
    expn_cyc.push_back(cyc + 3 + HN + 9*BN);
    send(1, 8'hA5, 1'b1, -1, -1);
    idle(10);

    done = 1'b1;
    idle(5);
    $display("FAIL bench did not reach its summary");
    $fatal(1);
  end

endmodule
